// File: rtl/output_fetch_serializer_if.sv
// Memory read port and element stream of the output fetch serializer.
interface output_fetch_serializer_if #(
    parameter int BUS_W  = 128,
    parameter int ELEM_W = 8,
    parameter int ADDR_W = 16
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [BUS_W-1:0]  rd_data;
    logic [ELEM_W-1:0] out_data;
    logic              out_bank;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output rd_en, rd_addr,
        input  rd_data,
        output out_data, out_bank, out_valid,
        input  out_ready
    );

    modport slave (
        input  rd_en, rd_addr,
        output rd_data,
        input  out_data, out_bank, out_valid,
        output out_ready
    );
endinterface

// File: rtl/output_fetch_serializer.sv
// Output-stage fetch engine: reads FRAME_WORDS words from the selected bank
// and streams each word out LSB-slice first as ELEM_W-bit elements.
module output_fetch_serializer #(
    parameter int BUS_W       = 128,
    parameter int ELEM_W      = 8,
    parameter int ADDR_W      = 16,
    parameter int FRAME_WORDS = 19200,
    parameter int RD_LAT      = 1,
    parameter int DONE_DELAY  = 12
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         bank_sel,
    output_fetch_serializer_if.master    bus,
    output logic                         busy,
    output logic                         done
);
    localparam int NELEM   = BUS_W / ELEM_W;
    localparam int K_W     = (NELEM > 1) ? $clog2(NELEM) : 1;
    localparam int IDX_W   = ADDR_W - 1;
    localparam int WAIT_W  = $clog2(RD_LAT + 1);
    localparam int FLUSH_W = $clog2(DONE_DELAY + 1);
    localparam logic [K_W-1:0]   K_LAST   = K_W'(NELEM - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_EMIT,
        S_FLUSH
    } state_t;

    state_t              r_state;
    logic                r_bank;
    logic [IDX_W-1:0]    r_index;
    logic [BUS_W-1:0]    r_word;
    logic [K_W-1:0]      r_k;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [FLUSH_W-1:0]  r_flush_cnt;
    logic                r_rd_en;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic [ELEM_W-1:0]   r_out_data;
    logic                r_out_bank;
    logic                r_out_valid;
    logic                r_busy;
    logic                r_done;

    logic                w_handshake;
    logic [BUS_W-1:0]    w_word_shift;
    logic [IDX_W-1:0]    w_next_index;

    assign w_handshake  = r_out_valid & bus.out_ready;
    assign w_word_shift = r_word >> ELEM_W;
    assign w_next_index = r_index + IDX_W'(1);

    assign bus.rd_en     = r_rd_en;
    assign bus.rd_addr   = r_rd_addr;
    assign bus.out_data  = r_out_data;
    assign bus.out_bank  = r_out_bank;
    assign bus.out_valid = r_out_valid;
    assign busy          = r_busy;
    assign done          = r_done;

    // Frame sequencer: fetch, wait for read data, serialise, then delay done.
    // The word register shifts right on each handshake so the current element
    // is always its low slice; FLUSH runs one extra count (0) to hold busy
    // through the done cycle before returning to IDLE.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_bank      <= 1'b0;
            r_index     <= '0;
            r_word      <= '0;
            r_k         <= '0;
            r_wait_cnt  <= '0;
            r_flush_cnt <= '0;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= '0;
            r_out_data  <= '0;
            r_out_bank  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else if (abort && (r_state != S_IDLE)) begin
            r_state     <= S_IDLE;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= '0;
            r_out_data  <= '0;
            r_out_bank  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start && !abort) begin
                        r_bank    <= bank_sel;
                        r_index   <= '0;
                        r_busy    <= 1'b1;
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= {bank_sel, IDX_W'(0)};
                        r_state   <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_rd_en    <= 1'b0;
                    r_rd_addr  <= '0;
                    r_wait_cnt <= WAIT_W'(RD_LAT);
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_wait_cnt == WAIT_W'(1)) begin
                        r_word      <= bus.rd_data;
                        r_k         <= '0;
                        r_out_data  <= bus.rd_data[ELEM_W-1:0];
                        r_out_bank  <= r_bank;
                        r_out_valid <= 1'b1;
                        r_state     <= S_EMIT;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - WAIT_W'(1);
                    end
                end
                S_EMIT: begin
                    if (w_handshake) begin
                        if (r_k == K_LAST) begin
                            r_out_valid <= 1'b0;
                            r_out_data  <= '0;
                            r_out_bank  <= 1'b0;
                            if (r_index != IDX_LAST) begin
                                r_index   <= w_next_index;
                                r_rd_en   <= 1'b1;
                                r_rd_addr <= {r_bank, w_next_index};
                                r_state   <= S_FETCH;
                            end else begin
                                r_flush_cnt <= FLUSH_W'(DONE_DELAY);
                                r_state     <= S_FLUSH;
                            end
                        end else begin
                            r_k        <= r_k + K_W'(1);
                            r_word     <= w_word_shift;
                            r_out_data <= w_word_shift[ELEM_W-1:0];
                        end
                    end
                end
                S_FLUSH: begin
                    if (r_flush_cnt == FLUSH_W'(1)) begin
                        r_done      <= 1'b1;
                        r_flush_cnt <= '0;
                    end else if (r_flush_cnt == '0) begin
                        r_done  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - FLUSH_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/output_fetch_serializer.md
# output_fetch_serializer

Parametrised output-stage fetch engine. On `start` it reads a frame of `FRAME_WORDS` wide words from result memory in the selected bank and serialises each word into `ELEM_W`-bit elements. Elements go out on a valid/ready stream toward the output formatter. It succeeds the fixed 128-bit/8-bit/19200-word fetch stage, adding parametrisation, downstream backpressure, configurable memory read latency, an abort, and a well-defined delayed `done` pulse.

## Interface
Parameters:
- `BUS_W`, 128: memory read word width; must be a multiple of `ELEM_W`.
- `ELEM_W`, 8: output element width.
- `ADDR_W`, 16: memory address width; MSB is the bank bit.
- `FRAME_WORDS`, 19200: words per frame, 1 to 2^(ADDR_W-1).
- `RD_LAT`, 1: memory read latency in cycles, ≥1.
- `DONE_DELAY`, 12: cycles from final element handshake to `done`, ≥1.

Ports:
- `clock` in 1: clock; all logic on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: frame request, sampled in IDLE only.
- `abort` in 1: synchronous frame cancel.
- `bank_sel` in 1: bank select, latched when `start` is accepted.
- `rd_en` out 1: memory read strobe.
- `rd_addr` out ADDR_W: {bank, word index}.
- `rd_data` in BUS_W: memory read data.
- `out_data` out ELEM_W: current element.
- `out_bank` out 1: latched bank, qualified by `out_valid`.
- `out_valid` out 1: element available.
- `out_ready` in 1: downstream accepts.
- `busy` out 1: frame in progress, including the done delay.
- `done` out 1: one-cycle pulse at frame completion.

## Operation
- States:
  - IDLE.
  - FETCH: one cycle, `rd_en`=1.
  - WAIT: RD_LAT cycles.
  - EMIT: serialise the word.
  - FLUSH: DONE_DELAY countdown.
- IDLE with `start`=1 and `abort`=0:
  - latch `bank_sel`;
  - set word index 0 and `busy`=1;
  - go to FETCH.
- FETCH drives `rd_addr` = {bank, index}, where index is ADDR_W-1 bits zero-extended, then goes to WAIT.
- The last WAIT cycle's edge captures `rd_data` into the word register, sets element counter 0, and goes to EMIT.
- EMIT:
  - `out_valid`=1.
  - `out_data` = word[(k+1)*ELEM_W-1 : k*ELEM_W] for counter k; element 0 is the least-significant slice and goes out first.
  - Handshake is `out_valid`&`out_ready`; each handshake increments k.
- Handshake on the last element (k = BUS_W/ELEM_W-1):
  - if the index is not FRAME_WORDS-1: increment the index and go to FETCH;
  - otherwise go to FLUSH with counter = DONE_DELAY.
- FLUSH decrements every cycle. At 1 it pulses `done`=1 for one cycle, clears `busy`, and goes to IDLE.
- While `out_valid`=1 and `out_ready`=0, `out_data`, `out_bank` and `out_valid` hold stable.
- `abort`=1 in any non-IDLE state returns to IDLE next edge:
  - `out_valid`, `rd_en` and `busy` go to 0;
  - `done` is not pulsed.
  - `abort` wins over a same-cycle handshake.
- `start` outside IDLE is ignored. `abort` in IDLE is ignored. `start` and `abort` together in IDLE: the start is ignored.
- Outputs are 0 in IDLE: `out_data`, `out_bank`, `rd_addr`, `rd_en`, `out_valid`.

## Timing
- Reset: all state to IDLE. All outputs 0: `rd_en`, `rd_addr`, `out_data`, `out_bank`, `out_valid`, `busy`, `done`. Reset mid-frame aborts immediately; no `done`.
- Start accepted at edge E0:
  - `busy`=1 after E0;
  - `rd_en` high during cycle E0→E1;
  - `rd_data` captured at edge E1+RD_LAT;
  - `out_valid`=1 from that edge.
  - Start-to-first-valid latency is 1+RD_LAT cycles.
- Per word:
  - with `out_ready` held 1: BUS_W/ELEM_W emit cycles + 1 fetch + RD_LAT wait;
  - no prefetch, so inter-word gap is 1+RD_LAT cycles with `out_valid`=0.
- Final handshake at edge Ef: `done` high during cycle Ef+DONE_DELAY → Ef+DONE_DELAY+1; `busy` falls at the end of that cycle.
- A new `start` is accepted in the cycle after `done`.

## Test plan
- **Basic frame.** Config BUS_W=32, ELEM_W=8, FRAME_WORDS=2, RD_LAT=1, DONE_DELAY=3, `out_ready`=1; memory[0]=0x44332211, memory[1]=0x88776655; start with `bank_sel`=0. Required:
  - `out_data` sequence 11,22,33,44,55,66,77,88;
  - first `out_valid` 2 cycles after start;
  - `done` one cycle, exactly 3 cycles after the 0x88 handshake.
- **Bank select.** `bank_sel`=1, ADDR_W=16. Required: `rd_addr` = 0x8000 then 0x8001; `out_bank`=1 on all elements.
- **Backpressure.** Same config; `out_ready` toggles 1,0,0,1 repeatedly. Required: 8 elements in order with no duplicates or drops; `out_data` stable during every `out_ready`=0 stall.
- **Latency sweep.** RD_LAT=3. Required: first `out_valid` 4 cycles after start; 4-cycle `out_valid`=0 gap between words.
- **Abort.** Abort asserted mid-word 1 (after the 0x55 handshake). Required:
  - `out_valid`, `busy` and `rd_en` are 0 the next cycle;
  - no `done`;
  - a subsequent `start` replays from word 0 (first element 0x11).
- **Reset and ignored start.** Assert `reset_n`=0 during FLUSH: all outputs 0, no `done`. Pulse `start` while busy: no effect on the sequence or the `done` timing.
